// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared types and constants for the equalizer's codec serial interface.
//   sample_t      : signed 16-bit audio sample
//   SCLK_RISE/FALL: frame-counter low bits on the cycle before an SCLK edge
//   LFT_DONE      : counter value on which the last left ADC bit is sampled
//   RHT_DONE      : counter value on which the last right ADC bit is sampled
//   TX_LD_L/R     : counter values on which the DAC shifter is reloaded
//   VLD_LEN_DEF   : default length of the valid window in clk cycles
//   shift_in16()  : one MSB-first shift step with a new LSB
// ---------------------------------------------------------------------------
package eq_pkg;

    typedef logic signed [15:0] sample_t;

    localparam logic [4:0] SCLK_RISE = 5'h0F;
    localparam logic [4:0] SCLK_FALL = 5'h1F;
    localparam logic [9:0] LFT_DONE  = 10'h1EF;
    localparam logic [9:0] RHT_DONE  = 10'h3EF;
    localparam logic [9:0] TX_LD_L   = 10'h3FF;
    localparam logic [9:0] TX_LD_R   = 10'h1FF;

    localparam int VLD_LEN_DEF = 256;

    // Shift a word left by one, entering a new bit at the LSB.
    function automatic logic [15:0] shift_in16(input logic [15:0] word,
                                               input logic        bit_in);
        return {word[14:0], bit_in};
    endfunction

endpackage

// File: rtl/i2s_shift16.sv
// ---------------------------------------------------------------------------
// i2s_shift16
// 16-bit shift register with parallel load and shift enable. Data moves
// toward the MSB; sin enters at the LSB. Load wins over shift.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   ld, ld_val : parallel load strobe and value
//   sh_en, sin : shift enable and serial input bit
//   q          : register contents (q[15] is the serial output)
// ---------------------------------------------------------------------------
module i2s_shift16
    import eq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] ld_val,
    input  logic        sh_en,
    input  logic        sin,
    output logic [15:0] q
);

    logic [15:0] shift_q;
    logic [15:0] shift_d;

    // Next value: load has priority over shift.
    always_comb begin
        shift_d = shift_q;
        if (ld) begin
            shift_d = ld_val;
        end else if (sh_en) begin
            shift_d = shift_in16(shift_q, sin);
        end else begin
            shift_d = shift_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 16'h0000;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/i2s_codec_intf.sv
// ---------------------------------------------------------------------------
// i2s_codec_intf
// Codec serial front/back end for the EQ datapath. A free-running frame
// counter produces MCLK/SCLK/LRCLK; left-justified 16-bit stereo ADC data
// is deserialized from SDin and DAC data is serialized onto SDout.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   lft_eq, rht_eq      : processed samples from the EQ (DAC data)
//   SDin                : serial ADC data from the codec
//   lft_smpl, rht_smpl  : parallel ADC samples to the EQ
//   valid/_rise/_fall   : fresh-sample window and its edge pulses
//   MCLK, SCLK, LRCLK   : codec clocks (LRCLK 0 = left half)
//   RSTn                : codec reset, active low
//   SDout               : serial DAC data to the codec
// ---------------------------------------------------------------------------
module i2s_codec_intf
    import eq_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int VLD_LEN = VLD_LEN_DEF
)
(
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t lft_eq,
    input  sample_t rht_eq,
    input  logic    SDin,
    output sample_t lft_smpl,
    output sample_t rht_smpl,
    output logic    valid,
    output logic    valid_rise,
    output logic    valid_fall,
    output logic    MCLK,
    output logic    SCLK,
    output logic    LRCLK,
    output logic    RSTn,
    output logic    SDout
);

    // Last counter value inside the valid window (wraps past the frame end).
    localparam logic [CNT_W-1:0] VLD_LAST = CNT_W'(int'(RHT_DONE) + VLD_LEN);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             rstn_q,       rstn_d;
    logic             primed_q,     primed_d;
    sample_t          lft_hold_q,   lft_hold_d;
    sample_t          rht_hold_q,   rht_hold_d;
    sample_t          lft_smpl_q,   lft_smpl_d;
    sample_t          rht_smpl_q,   rht_smpl_d;
    logic             valid_q,      valid_d;
    logic             vrise_q,      vrise_d;
    logic             vfall_q,      vfall_d;

    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        tx_ld_l_s;
    logic        tx_ld_r_s;
    logic        tx_ld_s;
    logic [15:0] tx_val_s;
    logic        tx_sh_s;
    logic        publish_s;
    logic        vld_end_s;
    logic [15:0] rx_q;
    logic [15:0] rx_next_s;
    logic [15:0] tx_q;

    // ADC deserializer: MSB arrives first, so shifting toward bit 15 lines it up.
    i2s_shift16 u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (1'b0),
        .ld_val (16'h0000),
        .sh_en  (sclk_rise_s),
        .sin    (SDin),
        .q      (rx_q)
    );

    // DAC serializer: q[15] is the bit currently on the wire.
    i2s_shift16 u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (tx_ld_s),
        .ld_val (tx_val_s),
        .sh_en  (tx_sh_s),
        .sin    (1'b0),
        .q      (tx_q)
    );

    // Frame decode, next-state for counter, codec reset, holds and valid flags.
    always_comb begin
        sclk_rise_s = (cnt_q[4:0] == SCLK_RISE);
        sclk_fall_s = (cnt_q[4:0] == SCLK_FALL);
        tx_ld_l_s   = (cnt_q == TX_LD_L);
        tx_ld_r_s   = (cnt_q == TX_LD_R);
        tx_ld_s     = tx_ld_l_s | tx_ld_r_s;
        tx_val_s    = tx_ld_l_s ? 16'(lft_eq) : 16'(rht_hold_q);
        // Load cycles are also SCLK-fall cycles; the load must win.
        tx_sh_s     = sclk_fall_s & ~tx_ld_s;
        // rx contents once this cycle's bit is shifted in.
        rx_next_s   = shift_in16(rx_q, SDin);
        // The first right word completed with the codec out of reset primes the path.
        publish_s   = (cnt_q == RHT_DONE) & (primed_q | rstn_q);
        vld_end_s   = valid_q & (cnt_q == VLD_LAST);

        cnt_d       = cnt_q + CNT_W'(1);
        rstn_d      = rstn_q | (&cnt_q);
        primed_d    = primed_q | publish_s;
        rht_hold_d  = tx_ld_l_s ? rht_eq : rht_hold_q;
        lft_hold_d  = (cnt_q == LFT_DONE) ? sample_t'(rx_next_s) : lft_hold_q;
        lft_smpl_d  = lft_smpl_q;
        rht_smpl_d  = rht_smpl_q;
        valid_d     = valid_q;
        vrise_d     = publish_s;
        vfall_d     = vld_end_s;

        if (publish_s) begin
            lft_smpl_d = lft_hold_q;
            rht_smpl_d = sample_t'(rx_next_s);
            valid_d    = 1'b1;
        end else if (vld_end_s) begin
            valid_d    = 1'b0;
        end else begin
            valid_d    = valid_q;
        end
    end

    // Interface state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rstn_q     <= 1'b0;
            primed_q   <= 1'b0;
            lft_hold_q <= 16'sh0000;
            rht_hold_q <= 16'sh0000;
            lft_smpl_q <= 16'sh0000;
            rht_smpl_q <= 16'sh0000;
            valid_q    <= 1'b0;
            vrise_q    <= 1'b0;
            vfall_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rstn_q     <= rstn_d;
            primed_q   <= primed_d;
            lft_hold_q <= lft_hold_d;
            rht_hold_q <= rht_hold_d;
            lft_smpl_q <= lft_smpl_d;
            rht_smpl_q <= rht_smpl_d;
            valid_q    <= valid_d;
            vrise_q    <= vrise_d;
            vfall_q    <= vfall_d;
        end
    end

    assign MCLK       = cnt_q[1];
    assign SCLK       = cnt_q[4];
    assign LRCLK      = cnt_q[CNT_W-1];
    assign RSTn       = rstn_q;
    assign SDout      = tx_q[15];
    assign lft_smpl   = lft_smpl_q;
    assign rht_smpl   = rht_smpl_q;
    assign valid      = valid_q;
    assign valid_rise = vrise_q;
    assign valid_fall = vfall_q;

endmodule

// File: tb/tb_i2s_codec_intf.sv
// ---------------------------------------------------------------------------
// tb_i2s_codec_intf
// Directed, table-driven bench for i2s_codec_intf. A bench-side frame counter
// (reset by rst_n, like the design's) drives a left-justified codec model on
// SDin and tells the bench where in the frame it is.
// ---------------------------------------------------------------------------
module tb_i2s_codec_intf;

    logic        clk;
    logic        rst_n;
    logic [15:0] lft_eq;
    logic [15:0] rht_eq;
    logic        sdin;
    logic [15:0] lft_smpl;
    logic [15:0] rht_smpl;
    logic        valid;
    logic        valid_rise;
    logic        valid_fall;
    logic        mclk;
    logic        sclk;
    logic        lrclk;
    logic        rstn_codec;
    logic        sdout;

    int checks = 0;
    int errors = 0;

    i2s_codec_intf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lft_eq     (lft_eq),
        .rht_eq     (rht_eq),
        .SDin       (sdin),
        .lft_smpl   (lft_smpl),
        .rht_smpl   (rht_smpl),
        .valid      (valid),
        .valid_rise (valid_rise),
        .valid_fall (valid_fall),
        .MCLK       (mclk),
        .SCLK       (sclk),
        .LRCLK      (lrclk),
        .RSTn       (rstn_codec),
        .SDout      (sdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench frame position: equals the frame counter of the design between edges.
    logic [9:0] tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 10'd0;
        else        tb_cnt <= tb_cnt + 10'd1;
    end

    // Codec model: MSB first, bit changes when the counter enters a new SCLK period.
    logic [15:0] cw_l;
    logic [15:0] cw_r;
    logic        loop_en;
    always_comb begin
        if (loop_en) sdin = sdout;
        else if (tb_cnt[9]) sdin = cw_r[4'd15 - tb_cnt[8:5]];
        else sdin = cw_l[4'd15 - tb_cnt[8:5]];
    end

    typedef struct {
        logic [15:0] cw_l;
        logic [15:0] cw_r;
        logic [15:0] eq_l;
        logic [15:0] eq_r;
        logic [15:0] late_l;
        logic [15:0] late_r;
        logic        loop;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cnt(input logic [9:0] target, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != target && n < 2100);
        if (tb_cnt != target) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=%0h required=%0h", tag, tb_cnt, target);
        end
    endtask

    function automatic logic clk_out(input int which);
        case (which)
            0:       return mclk;
            1:       return sclk;
            2:       return lrclk;
            default: return 1'b0;
        endcase
    endfunction

    task automatic meas_period(input int which, output int per);
        logic prev;
        logic cur;
        int   n;
        int   rises;
        int   t0;
        per   = -1;
        n     = 0;
        rises = 0;
        t0    = 0;
        prev  = clk_out(which);
        while (rises < 2 && n < 3000) begin
            @(negedge clk);
            n++;
            cur = clk_out(which);
            if (!prev && cur) begin
                rises++;
                if (rises == 1) t0 = n;
                else per = n - t0;
            end
            prev = cur;
        end
    endtask

    initial begin
        int          n;
        int          vcnt;
        int          per;
        int          hi;
        int          rises;
        int          falls;
        int          both;
        int          last_rise;
        logic [31:0] sd_bits;

        vecs[0] = '{16'hA5C3, 16'h7FFF, 16'h8001, 16'h1234, 16'h8001, 16'h1234, 1'b0, 16'hA5C3, 16'h7FFF};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h8000, 16'h0000};
        vecs[3] = '{16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0001};

        rst_n   = 1'b0;
        lft_eq  = 16'h0000;
        rht_eq  = 16'h0000;
        cw_l    = 16'h0000;
        cw_r    = 16'h0000;
        loop_en = 1'b0;

        // Reset state.
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {valid, valid_rise, valid_fall, mclk, sclk, lrclk, rstn_codec, sdout}, 8'h00);
        chk("reset_lft", lft_smpl, 16'h0000);
        chk("reset_rht", rht_smpl, 16'h0000);

        // Codec reset release: RSTn goes high with the 1024th rising edge after
        // release (the 1025th clk period counting the one holding the release).
        rst_n = 1'b1;
        n = 0;
        vcnt = 0;
        while (!rstn_codec && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("rstn_rise_edges", n, 1024);
        chk("valid_before_rstn", vcnt, 0);

        meas_period(0, per);
        chk("mclk_period", per, 4);
        meas_period(1, per);
        chk("sclk_period", per, 32);
        meas_period(2, per);
        chk("lrclk_period", per, 1024);

        // Frame vectors: ADC capture, DAC serialization, late EQ change, loopback.
        for (int i = 0; i < 4; i++) begin
            wait_cnt(10'h3F8, "setup");
            cw_l    = vecs[i].cw_l;
            cw_r    = vecs[i].cw_r;
            lft_eq  = vecs[i].eq_l;
            rht_eq  = vecs[i].eq_r;
            loop_en = vecs[i].loop;
            wait_cnt(10'h005, "late");
            lft_eq  = vecs[i].late_l;
            rht_eq  = vecs[i].late_r;
            for (int j = 0; j < 32; j++) begin
                wait_cnt(10'(j * 32 + 16), "sclk_rise");
                sd_bits[31 - j] = sdout;
            end
            wait_cnt(10'h3F0, "publish");
            chk($sformatf("v%0d_lft_smpl", i), lft_smpl, vecs[i].exp_l);
            chk($sformatf("v%0d_rht_smpl", i), rht_smpl, vecs[i].exp_r);
            chk($sformatf("v%0d_valid_rise", i), {valid, valid_rise}, 2'b11);
            chk($sformatf("v%0d_sdout_l", i), sd_bits[31:16], vecs[i].eq_l);
            chk($sformatf("v%0d_sdout_r", i), sd_bits[15:0], vecs[i].eq_r);
        end

        // Valid window timing over four frames.
        loop_en = 1'b0;
        wait_cnt(10'h100, "valid_win");
        hi = 0; rises = 0; falls = 0; both = 0; last_rise = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            if (valid) hi++;
            if (valid_rise && valid_fall) both++;
            if (valid_rise) begin
                rises++;
                last_rise = k;
                chk("valid_rise_pos", tb_cnt, 10'h3F0);
            end
            if (valid_fall) begin
                falls++;
                chk("rise_to_fall", k - last_rise, 256);
            end
        end
        chk("valid_high_cycles", hi, 1024);
        chk("valid_rise_count", rises, 4);
        chk("valid_fall_count", falls, 4);
        chk("rise_fall_overlap", both, 0);

        // Mid-frame reset during right-word capture.
        wait_cnt(10'h3F8, "mid_setup");
        cw_l   = 16'h1357;
        cw_r   = 16'h2468;
        lft_eq = 16'h0000;
        rht_eq = 16'h0000;
        wait_cnt(10'h2A0, "mid_point");
        chk("pre_reset_rstn", rstn_codec, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ctl", {valid, valid_rise, valid_fall, mclk, sclk, lrclk, rstn_codec, sdout}, 8'h00);
        chk("mid_reset_lft", lft_smpl, 16'h0000);
        chk("mid_reset_rht", rht_smpl, 16'h0000);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        vcnt = 0;
        while (!valid_rise && n < 4000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid && !valid_rise) vcnt++;
        end
        chk("restart_first_rise", n, 2032);
        chk("restart_early_valid", vcnt, 0);
        chk("restart_lft", lft_smpl, 16'h1357);
        chk("restart_rht", rht_smpl, 16'h2468);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
